// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - UART and register-bus signal bundle for uart_cmd_ctrl
//
// Purpose: groups the receive, transmit, register-bus and error signals
// of the frame controller so they travel as one port.
// Ports (named from the controller's point of view):
//   i_RX_DV, i_RX_Byte      received byte strobe and value
//   o_TX_DV, o_TX_Byte      reply byte start pulse and value
//   i_TX_Done               transmitter finished pulse
//   o_Bus_Addr, o_Bus_Wr_En, o_Bus_Wr_Data, o_Bus_Rd_En, i_Bus_Rd_Data
//                           byte-wide register bus
//   o_Err, o_Err_Code, o_Err_Count
//                           rejected-frame pulse, last code, saturating count
// Modports: master = frame controller, slave = UART plus register file.
interface uart_cmd_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_TX_Done;
  logic [7:0] o_Bus_Addr;
  logic       o_Bus_Wr_En;
  logic [7:0] o_Bus_Wr_Data;
  logic       o_Bus_Rd_En;
  logic [7:0] i_Bus_Rd_Data;
  logic       o_Err;
  logic [1:0] o_Err_Code;
  logic [7:0] o_Err_Count;

  modport master (
    input  i_RX_DV, i_RX_Byte, i_TX_Done, i_Bus_Rd_Data,
    output o_TX_DV, o_TX_Byte, o_Bus_Addr, o_Bus_Wr_En, o_Bus_Wr_Data,
           o_Bus_Rd_En, o_Err, o_Err_Code, o_Err_Count
  );

  modport slave (
    output i_RX_DV, i_RX_Byte, i_TX_Done, i_Bus_Rd_Data,
    input  o_TX_DV, o_TX_Byte, o_Bus_Addr, o_Bus_Wr_En, o_Bus_Wr_Data,
           o_Bus_Rd_En, o_Err, o_Err_Code, o_Err_Count
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command-frame controller driving a byte-wide register bus
//
// Purpose: assembles SYNC, CMD, ADDR, DATA, CHK frames (CHK = CMD^ADDR^DATA),
// turns good writes into a one-cycle write strobe and good reads into a
// one-cycle read strobe followed by a one-byte UART reply.
// Ports:
//   i_Clock   system clock
//   i_Reset   synchronous reset, active high
//   bus       uart_cmd_ctrl_if.master (RX/TX handshakes, register bus, error status)
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter logic [7:0] CMD_WR       = 8'h01,
  parameter logic [7:0] CMD_RD       = 8'h02,
  parameter int         TIMEOUT_CLKS = 21700
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  uart_cmd_ctrl_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK,
    S_EXEC_WR, S_EXEC_RD, S_RD_CAP, S_TX_WAIT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] to_cnt;
  logic [7:0]    cmd_q, addr_q, data_q;
  logic          in_frame, timeout, err_n;
  logic [1:0]    err_code_n;

  assign in_frame = (state == S_CMD) || (state == S_ADDR) ||
                    (state == S_DATA) || (state == S_CHK);
  // A byte in the expiry cycle wins over the timeout.
  assign timeout  = in_frame && !bus.i_RX_DV && (to_cnt == CW'(TIMEOUT_CLKS - 1));

  always_comb begin
    state_n    = state;
    err_n      = 1'b0;
    err_code_n = 2'd0;
    case (state)
      S_IDLE:    if (bus.i_RX_DV && bus.i_RX_Byte == SYNC_BYTE) state_n = S_CMD;
      S_CMD:
        if (bus.i_RX_DV) begin
          if (bus.i_RX_Byte == CMD_WR || bus.i_RX_Byte == CMD_RD) begin
            state_n = S_ADDR;
          end else begin
            state_n    = S_IDLE;
            err_n      = 1'b1;
            err_code_n = 2'd1;
          end
        end
      S_ADDR:    if (bus.i_RX_DV) state_n = S_DATA;
      S_DATA:    if (bus.i_RX_DV) state_n = S_CHK;
      S_CHK:
        if (bus.i_RX_DV) begin
          if (bus.i_RX_Byte == (cmd_q ^ addr_q ^ data_q)) begin
            state_n = (cmd_q == CMD_WR) ? S_EXEC_WR : S_EXEC_RD;
          end else begin
            state_n    = S_IDLE;
            err_n      = 1'b1;
            err_code_n = 2'd2;
          end
        end
      S_EXEC_WR: state_n = S_IDLE;
      S_EXEC_RD: state_n = S_RD_CAP;
      S_RD_CAP:  state_n = S_TX_WAIT;
      S_TX_WAIT: if (bus.i_TX_Done) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (timeout) begin
      state_n    = S_IDLE;
      err_n      = 1'b1;
      err_code_n = 2'd3;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state             <= S_IDLE;
      to_cnt            <= '0;
      cmd_q             <= 8'd0;
      addr_q            <= 8'd0;
      data_q            <= 8'd0;
      bus.o_TX_DV       <= 1'b0;
      bus.o_TX_Byte     <= 8'd0;
      bus.o_Bus_Addr    <= 8'd0;
      bus.o_Bus_Wr_En   <= 1'b0;
      bus.o_Bus_Wr_Data <= 8'd0;
      bus.o_Bus_Rd_En   <= 1'b0;
      bus.o_Err         <= 1'b0;
      bus.o_Err_Code    <= 2'd0;
      bus.o_Err_Count   <= 8'd0;
    end else begin
      state <= state_n;

      if (bus.i_RX_DV) begin
        case (state)
          S_CMD:   cmd_q  <= bus.i_RX_Byte;
          S_ADDR:  addr_q <= bus.i_RX_Byte;
          S_DATA:  data_q <= bus.i_RX_Byte;
          default: ;
        endcase
      end

      // Held at zero outside the frame states, so entry to CMD starts from 0.
      if (!in_frame || bus.i_RX_DV || timeout) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + 1'b1;

      // Bus address/data only change for a frame that will execute.
      if (state_n == S_EXEC_WR || state_n == S_EXEC_RD) bus.o_Bus_Addr <= addr_q;
      if (state_n == S_EXEC_WR) bus.o_Bus_Wr_Data <= data_q;

      // Write strobe lands in the cycle after EXEC_WR; the read strobe is
      // issued together with EXEC_RD so that read data is back in RD_CAP.
      bus.o_Bus_Wr_En <= (state == S_EXEC_WR);
      bus.o_Bus_Rd_En <= (state_n == S_EXEC_RD);

      bus.o_TX_DV <= (state == S_RD_CAP);
      if (state == S_RD_CAP) bus.o_TX_Byte <= bus.i_Bus_Rd_Data;

      bus.o_Err <= err_n;
      if (err_n) begin
        bus.o_Err_Code <= err_code_n;
        if (bus.o_Err_Count != 8'hFF) bus.o_Err_Count <= bus.o_Err_Count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  localparam int TO = 21700;

  logic clk = 1'b0;
  logic rst;
  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.TIMEOUT_CLKS(TO)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  // expected output events, slot = cycle % 8
  bit         e_wr[8], e_rd[8], e_tx[8], e_err[8];
  logic [7:0] e_waddr[8], e_wdata[8], e_raddr[8], e_txb[8];
  logic [1:0] m_code;
  logic [7:0] m_cnt;

  // frame model
  logic [7:0] fq[$];
  int last_acc, free_from, cap_cyc, wait_from;
  bit wait_done;

  // observed events
  int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
  int b_wr, b_rd, b_tx, b_err;
  logic [7:0] o_waddr, o_wdata, o_raddr, o_txb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic raise_err(input int c, input logic [1:0] code);
    e_err[(c + 1) % 8] = 1'b1;
    m_code = code;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic model_step(input int c);
    logic busy;
    logic [7:0] b;
    int s;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        e_wr[i] = 0; e_rd[i] = 0; e_tx[i] = 0; e_err[i] = 0;
      end
      fq.delete();
      m_code = 2'd0; m_cnt = 8'd0;
      free_from = 0; cap_cyc = -1; wait_done = 0; wait_from = 0; last_acc = 0;
      started = 1'b1;
      return;
    end
    if (!started) return;
    if (c == cap_cyc) begin
      s = (c + 1) % 8;
      e_tx[s] = 1'b1;
      e_txb[s] = bus.i_Bus_Rd_Data;
      wait_done = 1'b1;
      wait_from = c + 1;
    end
    busy = wait_done || (c < free_from);
    if (wait_done && bus.i_TX_Done && c >= wait_from) wait_done = 1'b0;
    if (busy) return;
    b = bus.i_RX_Byte;
    if (fq.size() == 0) begin
      if (bus.i_RX_DV && b == 8'hA5) begin
        fq.push_back(b);
        last_acc = c;
      end
    end else if (bus.i_RX_DV) begin
      fq.push_back(b);
      last_acc = c;
      if (fq.size() == 2 && b != 8'h01 && b != 8'h02) begin
        raise_err(c, 2'd1);
        fq.delete();
      end else if (fq.size() == 5) begin
        if (b == (fq[1] ^ fq[2] ^ fq[3])) begin
          if (fq[1] == 8'h01) begin
            s = (c + 2) % 8;
            e_wr[s] = 1'b1; e_waddr[s] = fq[2]; e_wdata[s] = fq[3];
            free_from = c + 2;
          end else begin
            s = (c + 1) % 8;
            e_rd[s] = 1'b1; e_raddr[s] = fq[2];
            cap_cyc = c + 2;
            free_from = c + 3;
          end
        end else begin
          raise_err(c, 2'd2);
        end
        fq.delete();
      end
    end else if (c - last_acc == TO) begin
      raise_err(c, 2'd3);
      fq.delete();
    end
  endtask

  always @(negedge clk) begin : cmp_proc
    int s;
    s = cyc % 8;
    if (started) begin
      chk("wr_en", bus.o_Bus_Wr_En, e_wr[s]);
      if (e_wr[s]) begin
        chk("wr_addr", bus.o_Bus_Addr, e_waddr[s]);
        chk("wr_data", bus.o_Bus_Wr_Data, e_wdata[s]);
      end
      chk("rd_en", bus.o_Bus_Rd_En, e_rd[s]);
      if (e_rd[s]) chk("rd_addr", bus.o_Bus_Addr, e_raddr[s]);
      chk("tx_dv", bus.o_TX_DV, e_tx[s]);
      if (e_tx[s]) chk("tx_byte", bus.o_TX_Byte, e_txb[s]);
      chk("err", bus.o_Err, e_err[s]);
      chk("err_code", bus.o_Err_Code, m_code);
      chk("err_count", bus.o_Err_Count, m_cnt);
      if (bus.o_Bus_Wr_En === 1'b1) begin n_wr++; o_waddr = bus.o_Bus_Addr; o_wdata = bus.o_Bus_Wr_Data; end
      if (bus.o_Bus_Rd_En === 1'b1) begin n_rd++; o_raddr = bus.o_Bus_Addr; end
      if (bus.o_TX_DV === 1'b1) begin n_tx++; o_txb = bus.o_TX_Byte; end
      if (bus.o_Err === 1'b1) n_err++;
    end
    e_wr[s] = 0; e_rd[s] = 0; e_tx[s] = 0; e_err[s] = 0;
    model_step(cyc);
    cyc++;
  end

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_RX_DV = 1'b1; bus.i_RX_Byte = b;
    @(posedge clk); #1;
    bus.i_RX_DV = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, b3, b4);
    pulse_rx(b0); pulse_rx(b1); pulse_rx(b2); pulse_rx(b3); pulse_rx(b4);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; bus.i_TX_Done = 1'b1;
    @(posedge clk); #1; bus.i_TX_Done = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic settle();
    wait_cyc(6);
    @(negedge clk); #1;
  endtask

  task automatic snap();
    b_wr = n_wr; b_rd = n_rd; b_tx = n_tx; b_err = n_err;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, bus.o_Bus_Wr_En, 0);
    chk({tag, "_rd_en"}, bus.o_Bus_Rd_En, 0);
    chk({tag, "_tx_dv"}, bus.o_TX_DV, 0);
    chk({tag, "_err"}, bus.o_Err, 0);
    chk({tag, "_addr"}, bus.o_Bus_Addr, 0);
    chk({tag, "_wdata"}, bus.o_Bus_Wr_Data, 0);
    chk({tag, "_txbyte"}, bus.o_TX_Byte, 0);
    chk({tag, "_code"}, bus.o_Err_Code, 0);
    chk({tag, "_count"}, bus.o_Err_Count, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_RX_DV = 1'b0; bus.i_RX_Byte = 8'h00;
    bus.i_TX_Done = 1'b0; bus.i_Bus_Rd_Data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check_zero("reset");

    // T1 write
    snap();
    frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    settle();
    chk("t1_wr_count", n_wr - b_wr, 1);
    chk("t1_addr", o_waddr, 8'h10);
    chk("t1_data", o_wdata, 8'h3C);
    chk("t1_err_count", n_err - b_err, 0);

    // T2 read, SYNC during TX_WAIT ignored, then next frame accepted
    snap();
    bus.i_Bus_Rd_Data = 8'h5A;
    frame(8'hA5, 8'h02, 8'h20, 8'h00, 8'h22);
    wait_cyc(4);
    @(negedge clk); #1;
    chk("t2_rd_count", n_rd - b_rd, 1);
    chk("t2_rd_addr", o_raddr, 8'h20);
    chk("t2_tx_count", n_tx - b_tx, 1);
    chk("t2_tx_byte", o_txb, 8'h5A);
    pulse_rx(8'hA5);
    chk("t2_tx_held", bus.o_TX_Byte, 8'h5A);
    pulse_done();
    frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    settle();
    chk("t5_busy_wr_count", n_wr - b_wr, 1);
    chk("t5_busy_err_count", n_err - b_err, 0);

    // T3 errors
    snap();
    frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2E);
    settle();
    chk("t3_bad_chk_wr", n_wr - b_wr, 0);
    chk("t3_bad_chk_code", bus.o_Err_Code, 2);
    chk("t3_bad_chk_count", bus.o_Err_Count, 1);
    pulse_rx(8'hA5); pulse_rx(8'h07);
    pulse_rx(8'h10); pulse_rx(8'h3C); pulse_rx(8'h2D);
    settle();
    chk("t3_bad_cmd_code", bus.o_Err_Code, 1);
    chk("t3_bad_cmd_count", bus.o_Err_Count, 2);

    // T5 noise before a frame
    snap();
    pulse_rx(8'h00); pulse_rx(8'hFF); pulse_rx(8'h3C);
    frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    settle();
    chk("t5_noise_wr_count", n_wr - b_wr, 1);
    chk("t5_noise_err_count", n_err - b_err, 0);

    // T4 timeout, then a byte exactly at expiry
    snap();
    pulse_rx(8'hA5); pulse_rx(8'h01); pulse_rx(8'h10);
    wait_cyc(TO + 5);
    @(negedge clk); #1;
    chk("t4_to_err_count", n_err - b_err, 1);
    chk("t4_to_code", bus.o_Err_Code, 3);
    chk("t4_to_count", bus.o_Err_Count, 3);
    snap();
    pulse_rx(8'hA5); pulse_rx(8'h01); pulse_rx(8'h10);
    wait_cyc(TO - 2);
    pulse_rx(8'h3C); pulse_rx(8'h2D);
    settle();
    chk("t4_edge_err_count", n_err - b_err, 0);
    chk("t4_edge_wr_count", n_wr - b_wr, 1);
    chk("t4_edge_count", bus.o_Err_Count, 3);

    // T6 reset after ADDR
    snap();
    pulse_rx(8'hA5); pulse_rx(8'h01); pulse_rx(8'h10);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check_zero("t6_reset");
    pulse_rx(8'h3C); pulse_rx(8'h2D);
    frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    settle();
    chk("t6_wr_count", n_wr - b_wr, 1);
    chk("t6_addr", o_waddr, 8'h10);
    chk("t6_err_count", n_err - b_err, 0);

    // reset in EXEC_WR cancels the strobe
    snap();
    frame(8'hA5, 8'h01, 8'h44, 8'h55, 8'h10);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    settle();
    chk("t6_exec_reset_wr", n_wr - b_wr, 0);

    // saturation
    for (int i = 0; i < 256; i++) begin
      pulse_rx(8'hA5); pulse_rx(8'h07);
    end
    settle();
    chk("t6_sat_count", bus.o_Err_Count, 8'hFF);
    chk("t6_sat_code", bus.o_Err_Code, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
